load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns a single load or store request into one word-aligned bus
// transaction, with lane steering, load extension, alignment checks and an ack timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   input  logic        mem_read,
   input  logic        mem_write,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        done,
   output logic        access_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state, state_nx;
   logic [7:0]  cnt;
   logic [2:0]  f3_q;
   logic [1:0]  lo_q;
   logic        to_q;

   logic        req, f3_err, align_err, err, start, expire;
   logic [3:0]  be_nx;
   logic [31:0] wdata_nx;
   logic [31:0] lane;
   logic [31:0] ld_val;

   assign req       = mem_read | mem_write;
   assign f3_err    = mem_write ? (funct3 > 3'b010)
                                : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
   assign align_err = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
   assign err       = req & (f3_err | align_err);
   assign start     = (state == IDLE) & req & ~err;
   assign expire    = (cnt == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      be_nx    = 4'b1111;
      wdata_nx = wdata;
      case (funct3[1:0])
         2'b00: begin
            be_nx    = 4'b0001 << addr[1:0];
            wdata_nx = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_nx    = 4'b0011 << addr[1:0];
            wdata_nx = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend by the latched funct3.
   assign lane = bus_rdata >> {lo_q, 3'b000};

   always_comb begin
      ld_val = bus_rdata;
      case (f3_q)
         3'b000:  ld_val = {{24{lane[7]}}, lane[7:0]};
         3'b001:  ld_val = {{16{lane[15]}}, lane[15:0]};
         3'b100:  ld_val = {24'd0, lane[7:0]};
         3'b101:  ld_val = {16'd0, lane[15:0]};
         default: ld_val = bus_rdata;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = BUSY;
         BUSY:    if (bus_ack || expire) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         f3_q      <= '0;
         lo_q      <= '0;
         to_q      <= 1'b0;
         rdata     <= '0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= be_nx;
                  bus_wdata <= wdata_nx;
                  bus_we    <= mem_write;
                  f3_q      <= funct3;
                  lo_q      <= addr[1:0];
                  cnt       <= '0;
                  to_q      <= 1'b0;
               end
            end
            BUSY: begin
               if (bus_ack) begin
                  if (!bus_we) rdata <= ld_val;
               end else if (expire) begin
                  rdata <= '0;
                  to_q  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus_req    = (state == BUSY);
   assign done       = (state == DONE);
   assign stall      = start | (state == BUSY);
   assign access_err = ((state == IDLE) & err) | ((state == DONE) & to_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a table of single transactions plus
// hand sequences for timeout, ack-on-expiry and reset during BUSY.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata;
   logic [2:0]  funct3;
   logic        mem_read, mem_write;
   logic [31:0] rdata;
   logic        stall, done, access_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_ack;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .funct3(funct3),
      .mem_read(mem_read), .mem_write(mem_write), .rdata(rdata), .stall(stall),
      .done(done), .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] brdata;
      logic        err;
      logic [3:0]  be;
      logic [31:0] baddr;
      logic [31:0] bwdata;
      logic        we;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      mem_read  = 1'b0;
      mem_write = 1'b0;
      funct3    = 3'b000;
      addr      = '0;
      wdata     = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;
   endtask

   task automatic run_vec(input int i);
      vec_t v;
      string n;
      v = vecs[i];
      n = $sformatf("v%0d", i);
      @(negedge clk);
      mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
      addr = v.addr; wdata = v.wdata; bus_ack = 1'b0;
      #1;
      check({n, ".idle_err"},   32'(access_err), 32'(v.err));
      check({n, ".idle_stall"}, 32'(stall),      32'(!v.err));
      if (v.err) begin
         @(negedge clk);
         check({n, ".err_noreq"}, 32'(bus_req),    32'd0);
         check({n, ".err_hold"},  32'(access_err), 32'd1);
         idle_inputs();
      end else begin
         @(negedge clk);
         check({n, ".bus_req"},   32'(bus_req),   32'd1);
         check({n, ".bus_addr"},  bus_addr,       v.baddr);
         check({n, ".bus_be"},    32'(bus_be),    32'(v.be));
         check({n, ".bus_wdata"}, bus_wdata,      v.bwdata);
         check({n, ".bus_we"},    32'(bus_we),    32'(v.we));
         check({n, ".busy_stall"},32'(stall),     32'd1);
         bus_ack = 1'b1; bus_rdata = v.brdata;
         @(negedge clk);
         idle_inputs();
         check({n, ".done"},      32'(done),       32'd1);
         check({n, ".done_stall"},32'(stall),      32'd0);
         check({n, ".done_req"},  32'(bus_req),    32'd0);
         check({n, ".done_err"},  32'(access_err), 32'd0);
         check({n, ".rdata"},     rdata,           v.rdata);
         @(negedge clk);
         check({n, ".done_once"}, 32'(done),       32'd0);
      end
   endtask

   initial begin
      // rd wr f3 addr wdata brdata err be baddr bwdata we rdata
      vecs[0]  = '{1,0,3'b000,32'h1003,32'h0,32'h80FF_FF12,0,4'b1000,32'h1000,32'h0,0,32'hFFFF_FF80};
      vecs[1]  = '{0,1,3'b001,32'h2002,32'h1234_ABCD,32'hDEAD_BEEF,0,4'b1100,32'h2000,32'hABCD_ABCD,1,32'hFFFF_FF80};
      vecs[2]  = '{1,0,3'b010,32'h3001,32'h0,32'h0,1,4'b0,32'h0,32'h0,0,32'h0};
      vecs[3]  = '{1,1,3'b010,32'h10,32'hCAFE_F00D,32'h5555_5555,0,4'b1111,32'h10,32'hCAFE_F00D,1,32'hFFFF_FF80};
      vecs[4]  = '{1,0,3'b100,32'h1,32'h0,32'h1234_9A78,0,4'b0010,32'h0,32'h0,0,32'h0000_009A};
      vecs[5]  = '{1,0,3'b001,32'h2,32'h0,32'h8001_7FFF,0,4'b1100,32'h0,32'h0,0,32'hFFFF_8001};
      vecs[6]  = '{1,0,3'b101,32'h0,32'h0,32'h1234_F00D,0,4'b0011,32'h0,32'h0,0,32'h0000_F00D};
      vecs[7]  = '{1,0,3'b010,32'h44,32'h0,32'h89AB_CDEF,0,4'b1111,32'h44,32'h0,0,32'h89AB_CDEF};
      vecs[8]  = '{0,1,3'b000,32'h5,32'h0000_00A5,32'h0,0,4'b0010,32'h4,32'hA5A5_A5A5,1,32'h89AB_CDEF};
      vecs[9]  = '{1,0,3'b001,32'h1,32'h0,32'h0,1,4'b0,32'h0,32'h0,0,32'h0};
      vecs[10] = '{1,0,3'b011,32'h0,32'h0,32'h0,1,4'b0,32'h0,32'h0,0,32'h0};
      vecs[11] = '{0,1,3'b100,32'h0,32'h0,32'h0,1,4'b0,32'h0,32'h0,0,32'h0};
      vecs[12] = '{1,0,3'b110,32'h0,32'h0,32'h0,1,4'b0,32'h0,32'h0,0,32'h0};
      vecs[13] = '{0,1,3'b010,32'h8,32'h1122_3344,32'h0,0,4'b1111,32'h8,32'h1122_3344,1,32'h89AB_CDEF};

      idle_inputs();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst.rdata",  rdata,            32'h0);
      check("rst.req",    32'(bus_req),     32'd0);
      check("rst.addr",   bus_addr,         32'h0);
      check("rst.be",     32'(bus_be),      32'd0);
      check("rst.wdata",  bus_wdata,        32'h0);
      check("rst.we",     32'(bus_we),      32'd0);
      check("rst.done",   32'(done),        32'd0);
      check("rst.err",    32'(access_err),  32'd0);
      check("rst.stall",  32'(stall),       32'd0);

      for (int i = 0; i < 14; i++) run_vec(i);

      // Ack with no request in IDLE must not start anything.
      @(negedge clk);
      bus_ack = 1'b1;
      @(negedge clk);
      check("idle_ack.req",  32'(bus_req), 32'd0);
      check("idle_ack.done", 32'(done),    32'd0);
      bus_ack = 1'b0;

      // LHU at 0x2 with no ack: four BUSY cycles then a timeout DONE.
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b101; addr = 32'h2;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         check($sformatf("to.busy%0d_req", c), 32'(bus_req), 32'd1);
         check($sformatf("to.busy%0d_done", c), 32'(done), 32'd0);
      end
      @(negedge clk);
      idle_inputs();
      check("to.done",  32'(done),       32'd1);
      check("to.err",   32'(access_err), 32'd1);
      check("to.rdata", rdata,           32'h0);
      check("to.req",   32'(bus_req),    32'd0);
      @(negedge clk);
      check("to.err_clr", 32'(access_err), 32'd0);

      // LBU at 0x3 with ack arriving in the 4th (expiry) BUSY cycle: ack wins.
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b100; addr = 32'h3;
      repeat (4) @(negedge clk);
      check("exp.busy4_req", 32'(bus_req), 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'hAB00_0000;
      @(negedge clk);
      idle_inputs();
      check("exp.done",  32'(done),       32'd1);
      check("exp.err",   32'(access_err), 32'd0);
      check("exp.rdata", rdata,           32'h0000_00AB);

      // Reset in the 2nd BUSY cycle, then a stale ack.
      @(negedge clk);
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h20;
      @(negedge clk);
      @(negedge clk);
      check("rb.busy2_req", 32'(bus_req), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      check("rb.req",   32'(bus_req), 32'd0);
      check("rb.rdata", rdata,        32'h0);
      check("rb.addr",  bus_addr,     32'h0);
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("rb.nodone%0d", c), 32'(done), 32'd0);
         check($sformatf("rb.noreq%0d", c), 32'(bus_req), 32'd0);
      end
      bus_ack = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
